// File: rtl/mux_key_pkg.sv
// mux_key_pkg: entry-layout width helpers shared by the key table and its matcher
package mux_key_pkg;
   // index width for an n-entry table, never narrower than one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   // an entry is packed as {valid, key, data}, data in the low bits
   function automatic int key_lsb(input int data_len);
      return data_len;
   endfunction
   function automatic int valid_bit(input int key_len, input int data_len);
      return key_len + data_len;
   endfunction
   function automatic int entry_w(input int key_len, input int data_len);
      return key_len + data_len + 1;
   endfunction
endpackage

// File: rtl/mux_key_match.sv
// mux_key_match: parallel key compare with lowest-index-wins priority encoder
module mux_key_match
   import mux_key_pkg::*;
#(
   parameter int NR_KEY  = 4,
   parameter int KEY_LEN = 2,
   localparam int IDX_W  = idx_w(NR_KEY)
) (
   input  logic [NR_KEY-1:0]         valid,
   input  logic [NR_KEY*KEY_LEN-1:0] keys,
   input  logic [KEY_LEN-1:0]        key,
   output logic                      hit,
   output logic [IDX_W-1:0]          idx
);
   // scan from the top down so the lowest matching index is the last one written
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (valid[i] && keys[i*KEY_LEN +: KEY_LEN] == key) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end
endmodule

// File: rtl/mux_key_table.sv
// mux_key_table: writable key/data table with a one-cycle lookup and a ready/valid response stage
module mux_key_table
   import mux_key_pkg::*;
#(
   parameter int NR_KEY      = 4,
   parameter int KEY_LEN     = 2,
   parameter int DATA_LEN    = 8,
   parameter bit HAS_DEFAULT = 1'b1,
   localparam int IDX_W      = idx_w(NR_KEY)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [KEY_LEN-1:0]  wr_key,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic                clr,
   input  logic [DATA_LEN-1:0] default_out,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [KEY_LEN-1:0]  req_key,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_LEN-1:0] rsp_data,
   output logic                rsp_hit,
   output logic [IDX_W-1:0]    rsp_idx
);
   localparam int KEY_LSB   = key_lsb(DATA_LEN);
   localparam int VALID_BIT = valid_bit(KEY_LEN, DATA_LEN);
   localparam int ENTRY_W   = entry_w(KEY_LEN, DATA_LEN);

   logic [ENTRY_W-1:0]        tbl [NR_KEY];
   logic [NR_KEY-1:0]         valid;
   logic [NR_KEY*KEY_LEN-1:0] keys;
   logic                      hit;
   logic [IDX_W-1:0]          idx;
   logic                      accept;

   assign req_ready = !rsp_valid || rsp_ready;
   assign accept    = req_valid && req_ready;

   // unpack valid bits and keys for the matcher
   always_comb begin
      valid = '0;
      keys  = '0;
      for (int i = 0; i < NR_KEY; i++) begin
         valid[i]                     = tbl[i][VALID_BIT];
         keys[i*KEY_LEN +: KEY_LEN]   = tbl[i][KEY_LSB +: KEY_LEN];
      end
   end

   mux_key_match #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN)) u_match (
      .valid (valid),
      .keys  (keys),
      .key   (req_key),
      .hit   (hit),
      .idx   (idx)
   );

   // table update: clear beats a same-cycle write, out-of-range writes are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR_KEY; i++) tbl[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < NR_KEY; i++) tbl[i][VALID_BIT] <= 1'b0;
      end else if (wr_en && int'(wr_idx) < NR_KEY) begin
         tbl[wr_idx] <= {1'b1, wr_key, wr_data};
      end
   end

   // response stage: capture on accept from pre-edge table contents, hold until consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_hit   <= 1'b0;
         rsp_idx   <= '0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_hit   <= hit;
         rsp_idx   <= idx;
         rsp_data  <= hit ? tbl[idx][DATA_LEN-1:0] : (HAS_DEFAULT ? default_out : '0);
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mux_key_table.sv
// tb_mux_key_table: directed lookup, priority, back-pressure, clear and reset checks
module tb_mux_key_table;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_idx = '0;
   logic [1:0] wr_key = '0;
   logic [7:0] wr_data = '0;
   logic       clr = 1'b0;
   logic [7:0] default_out = 8'hAA;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_key = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic       rsp_hit;
   logic [1:0] rsp_idx;
   int         checks = 0;
   int         failures = 0;

   mux_key_table dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
      .wr_data(wr_data), .clr(clr), .default_out(default_out),
      .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic h,
                            input logic [1:0] i, input logic [7:0] d);
      check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      check({tag, "_hit"},   32'(rsp_hit),   32'(h));
      check({tag, "_idx"},   32'(rsp_idx),   32'(i));
      check({tag, "_data"},  32'(rsp_data),  32'(d));
   endtask

   task automatic write(input logic [1:0] i, input logic [1:0] k, input logic [7:0] d);
      wr_en = 1'b1; wr_idx = i; wr_key = k; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      check_rsp("reset", 1'b0, 1'b0, 2'd0, 8'h00);
      check("reset_req_ready", 32'(req_ready), 32'd1);

      req_valid = 1'b1; req_key = 2'd2;
      step();
      req_valid = 1'b0;
      check_rsp("miss_default", 1'b1, 1'b0, 2'd0, 8'hAA);
      step();
      check("drain_valid", 32'(rsp_valid), 32'd0);

      write(2'd1, 2'd3, 8'h5C);
      req_valid = 1'b1; req_key = 2'd3;
      step();
      req_valid = 1'b0;
      check_rsp("hit_idx1", 1'b1, 1'b1, 2'd1, 8'h5C);

      write(2'd0, 2'd1, 8'h11);
      write(2'd2, 2'd1, 8'h22);
      req_valid = 1'b1; req_key = 2'd1;
      step();
      check_rsp("prio_low", 1'b1, 1'b1, 2'd0, 8'h11);

      req_key = 2'd3;
      step();
      check_rsp("pre_stall", 1'b1, 1'b1, 2'd1, 8'h5C);
      rsp_ready = 1'b0; req_key = 2'd1;
      wr_en = 1'b1; wr_idx = 2'd1; wr_key = 2'd3; wr_data = 8'h5D;
      for (int c = 0; c < 3; c++) begin
         step();
         wr_en = 1'b0;
         check("stall_req_ready", 32'(req_ready), 32'd0);
         check_rsp("stall_hold", 1'b1, 1'b1, 2'd1, 8'h5C);
      end
      rsp_ready = 1'b1;
      step();
      check_rsp("b2b_0", 1'b1, 1'b1, 2'd0, 8'h11);
      req_key = 2'd3;
      step();
      check_rsp("b2b_1", 1'b1, 1'b1, 2'd1, 8'h5D);
      req_key = 2'd0;
      step();
      check_rsp("b2b_2", 1'b1, 1'b0, 2'd0, 8'hAA);
      req_valid = 1'b0;
      step();
      check("b2b_drain", 32'(rsp_valid), 32'd0);

      req_valid = 1'b1; req_key = 2'd3; clr = 1'b1;
      wr_en = 1'b1; wr_idx = 2'd1; wr_key = 2'd3; wr_data = 8'h99;
      step();
      clr = 1'b0; wr_en = 1'b0;
      check_rsp("clr_old", 1'b1, 1'b1, 2'd1, 8'h5D);
      step();
      req_valid = 1'b0;
      default_out = 8'h55;
      #1;
      check_rsp("clr_miss", 1'b1, 1'b0, 2'd0, 8'hAA);
      default_out = 8'hAA;
      step();

      write(2'd0, 2'd1, 8'h11);
      rsp_ready = 1'b0; req_valid = 1'b1; req_key = 2'd1;
      step();
      check_rsp("pend", 1'b1, 1'b1, 2'd0, 8'h11);
      rst = 1'b1;
      step();
      check_rsp("rst_drop", 1'b0, 1'b0, 2'd0, 8'h00);
      step();
      check("rst_no_accept", 32'(rsp_valid), 32'd0);
      rst = 1'b0; rsp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      check_rsp("post_rst", 1'b1, 1'b0, 2'd0, 8'hAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
